// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the single-issue RV32I core: fetch, decode,
// execute, memory and writeback, with a retired-instruction counter and memory watchdog.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIM   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Last permitted wait_cnt value before a still-pending access is declared dead
    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);
    localparam logic        WDOG_EN    = (MEM_TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_instret;
    logic        r_halted;
    logic        r_fault;
    logic [15:0] r_wait_cnt;

    state_t      w_next;
    logic        w_fault_set;
    logic        w_retire;
    logic        w_legal;
    logic        w_wait;
    logic        w_timeout;
    logic        w_is_store;
    logic        w_is_ldst;

    assign w_is_store = (opcode == OP_STORE);
    assign w_is_ldst  = (opcode == OP_LOAD) || w_is_store;
    assign w_legal    = (opcode == OP_LOAD)   || (opcode == OP_STORE) || (opcode == OP_OP)
                     || (opcode == OP_OPIM)   || (opcode == OP_BRANCH) || (opcode == OP_JAL)
                     || (opcode == OP_JALR)   || (opcode == OP_LUI)    || (opcode == OP_AUIPC);
    assign w_wait     = ((r_state == S_FETCH) && !imem_ready) || ((r_state == S_MEM) && !dmem_ready);
    assign w_timeout  = WDOG_EN && w_wait && (r_wait_cnt == WAIT_LIMIT);

    always_comb begin
        w_next      = r_state;
        w_fault_set = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next      = S_HALT;
                    w_fault_set = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    w_next = S_HALT;
                end else if (!w_legal) begin
                    w_next      = S_HALT;
                    w_fault_set = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_ldst) begin
                    w_next = S_MEM;
                end else if (opcode == OP_BRANCH) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (w_is_store) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next      = S_HALT;
                    w_fault_set = 1'b1;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT: w_next = S_HALT;
            default: begin
                w_next      = S_HALT;
                w_fault_set = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_instret  <= 32'd0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
            r_wait_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT) r_halted <= 1'b1;
            if (w_fault_set) r_fault <= 1'b1;
            if (w_retire) r_instret <= r_instret + 32'd1;
            if (w_next != r_state) r_wait_cnt <= 16'd0;
            else if (w_wait) r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Strobes are decoded from the current state and live inputs; reset masks them all
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        wb_sel   = 2'd0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    if (opcode == OP_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? 2'd1 : 2'd0;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    pc_we    = dmem_ready && w_is_store;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    if (opcode == OP_LOAD) wb_sel = 2'd1;
                    else if ((opcode == OP_JAL) || (opcode == OP_JALR)) wb_sel = 2'd2;
                    else if (opcode == OP_LUI) wb_sel = 2'd3;
                    if (opcode == OP_JAL) pc_sel = 2'd1;
                    else if (opcode == OP_JALR) pc_sel = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign instret = r_instret;
    assign halted  = r_halted;
    assign fault   = r_fault;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a table of per-cycle vectors for a mixed
// instruction stream, then hand-written halt, watchdog and reset sequences.
module tb_core_sequencer;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] SYS = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we;
    logic [1:0]  pc_sel, wb_sel;
    logic        halted, fault;
    logic [2:0]  state;
    logic [31:0] instret;

    int total = 0;
    int bad = 0;

    core_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel),
        .halted(halted), .fault(fault), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic [6:0]  op;
        logic        bt, ir, dr;
        logic [2:0]  st;
        logic [5:0]  sb;   // {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we}
        logic [1:0]  ps, ws;
        logic [31:0] ic;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [6:0] op, input logic bt, ir, dr,
                               input logic [2:0] st, input logic [5:0] sb,
                               input logic [1:0] ps, ws, input logic [31:0] ic);
        vec_t r;
        r.op = op; r.bt = bt; r.ir = ir; r.dr = dr;
        r.st = st; r.sb = sb; r.ps = ps; r.ws = ws; r.ic = ic;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic bt, ir, dr, rst);
        @(negedge clk);
        opcode = op; branch_taken = bt; imem_ready = ir; dmem_ready = dr; reset = rst;
        #1;
    endtask

    task automatic expect_o(input string tag, input logic [2:0] st, input logic [5:0] sb,
                            input logic [1:0] ps, ws, input logic h, f, input logic [31:0] ic);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".strobes"}, 32'({imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we}), 32'(sb));
        chk({tag, ".sel"}, 32'({pc_sel, wb_sel}), 32'({ps, ws}));
        chk({tag, ".halt_fault"}, 32'({halted, fault}), 32'({h, f}));
        chk({tag, ".instret"}, instret, ic);
    endtask

    task automatic do_reset();
        drive(7'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst.strobes_masked", 32'({imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, wb_sel}), 32'd0);
    endtask

    initial begin
        // ADDI, LW with 3 dmem waits, SW, BEQ taken/not, JAL, JALR, LUI, AUIPC with 2 imem waits, OP
        tbl.push_back(v(OPI,0,1,1, 0,6'b110000,0,0,0));
        tbl.push_back(v(OPI,0,1,1, 1,6'b000000,0,0,0));
        tbl.push_back(v(OPI,0,1,1, 2,6'b000000,0,0,0));
        tbl.push_back(v(OPI,0,1,1, 4,6'b000011,0,0,0));
        tbl.push_back(v(LD ,0,1,1, 0,6'b110000,0,0,1));
        tbl.push_back(v(LD ,0,1,1, 1,6'b000000,0,0,1));
        tbl.push_back(v(LD ,0,1,1, 2,6'b000000,0,0,1));
        tbl.push_back(v(LD ,0,1,0, 3,6'b001000,0,0,1));
        tbl.push_back(v(LD ,0,1,0, 3,6'b001000,0,0,1));
        tbl.push_back(v(LD ,0,1,0, 3,6'b001000,0,0,1));
        tbl.push_back(v(LD ,0,1,1, 3,6'b001000,0,0,1));
        tbl.push_back(v(LD ,0,1,1, 4,6'b000011,0,1,1));
        tbl.push_back(v(ST ,0,1,1, 0,6'b110000,0,0,2));
        tbl.push_back(v(ST ,0,1,1, 1,6'b000000,0,0,2));
        tbl.push_back(v(ST ,0,1,1, 2,6'b000000,0,0,2));
        tbl.push_back(v(ST ,0,1,1, 3,6'b001101,0,0,2));
        tbl.push_back(v(BR ,1,1,1, 0,6'b110000,0,0,3));
        tbl.push_back(v(BR ,1,1,1, 1,6'b000000,0,0,3));
        tbl.push_back(v(BR ,1,1,1, 2,6'b000001,1,0,3));
        tbl.push_back(v(BR ,0,1,1, 0,6'b110000,0,0,4));
        tbl.push_back(v(BR ,0,1,1, 1,6'b000000,0,0,4));
        tbl.push_back(v(BR ,0,1,1, 2,6'b000001,0,0,4));
        tbl.push_back(v(JAL,0,1,1, 0,6'b110000,0,0,5));
        tbl.push_back(v(JAL,0,1,1, 1,6'b000000,0,0,5));
        tbl.push_back(v(JAL,0,1,1, 2,6'b000000,0,0,5));
        tbl.push_back(v(JAL,0,1,1, 4,6'b000011,1,2,5));
        tbl.push_back(v(JLR,0,1,1, 0,6'b110000,0,0,6));
        tbl.push_back(v(JLR,0,1,1, 1,6'b000000,0,0,6));
        tbl.push_back(v(JLR,0,1,1, 2,6'b000000,0,0,6));
        tbl.push_back(v(JLR,0,1,1, 4,6'b000011,2,2,6));
        tbl.push_back(v(LUI,0,1,1, 0,6'b110000,0,0,7));
        tbl.push_back(v(LUI,0,1,1, 1,6'b000000,0,0,7));
        tbl.push_back(v(LUI,0,1,1, 2,6'b000000,0,0,7));
        tbl.push_back(v(LUI,0,1,1, 4,6'b000011,0,3,7));
        tbl.push_back(v(AUI,0,0,1, 0,6'b100000,0,0,8));
        tbl.push_back(v(AUI,0,0,1, 0,6'b100000,0,0,8));
        tbl.push_back(v(AUI,0,1,1, 0,6'b110000,0,0,8));
        tbl.push_back(v(AUI,0,1,1, 1,6'b000000,0,0,8));
        tbl.push_back(v(AUI,0,1,1, 2,6'b000000,0,0,8));
        tbl.push_back(v(AUI,0,1,1, 4,6'b000011,0,0,8));
        tbl.push_back(v(OPR,0,1,1, 0,6'b110000,0,0,9));
        tbl.push_back(v(OPR,0,1,1, 1,6'b000000,0,0,9));
        tbl.push_back(v(OPR,0,1,1, 2,6'b000000,0,0,9));
        tbl.push_back(v(OPR,0,1,1, 4,6'b000011,0,0,9));

        do_reset();
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.instret", instret, 32'd0);
        chk("rst.halt_fault", 32'({halted, fault}), 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].bt, tbl[i].ir, tbl[i].dr, 1'b0);
            expect_o($sformatf("vec%0d", i), tbl[i].st, tbl[i].sb, tbl[i].ps, tbl[i].ws, 1'b0, 1'b0, tbl[i].ic);
        end

        // Illegal opcode 0000000 halts with fault after DECODE; instret stays at 10
        drive(7'd0, 0, 1, 1, 0); expect_o("ill.fetch", 0, 6'b110000, 0, 0, 0, 0, 10);
        drive(7'd0, 0, 1, 1, 0); expect_o("ill.dec", 1, 6'b000000, 0, 0, 0, 0, 10);
        for (int i = 0; i < 12; i++) begin
            drive(7'd0, 1, 1, 1, 0);
            expect_o($sformatf("ill.halt%0d", i), 5, 6'b000000, 0, 0, 1, 1, 10);
        end

        // ECALL halts cleanly after reset
        do_reset();
        drive(SYS, 0, 1, 1, 0); expect_o("ecall.fetch", 0, 6'b110000, 0, 0, 0, 0, 0);
        drive(SYS, 0, 1, 1, 0); expect_o("ecall.dec", 1, 6'b000000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            drive(BR, 1, 1, 1, 0);
            expect_o($sformatf("ecall.halt%0d", i), 5, 6'b000000, 0, 0, 1, 0, 0);
        end

        // imem stalled: exactly 4 FETCH cycles, then fault halt
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(OPI, 0, 0, 1, 0);
            expect_o($sformatf("itmo.fetch%0d", i), 0, 6'b100000, 0, 0, 0, 0, 0);
        end
        drive(OPI, 0, 1, 1, 0); expect_o("itmo.halt", 5, 6'b000000, 0, 0, 1, 1, 0);

        // 3 imem waits then ready: still legal
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(OPI, 0, 0, 1, 0);
            expect_o($sformatf("iok.fetch%0d", i), 0, 6'b100000, 0, 0, 0, 0, 0);
        end
        drive(OPI, 0, 1, 1, 0); expect_o("iok.ready", 0, 6'b110000, 0, 0, 0, 0, 0);
        drive(OPI, 0, 1, 1, 0); expect_o("iok.dec", 1, 6'b000000, 0, 0, 0, 0, 0);

        // dmem stalled 4 cycles in MEM: fault halt
        do_reset();
        drive(LD, 0, 1, 1, 0); expect_o("dtmo.fetch", 0, 6'b110000, 0, 0, 0, 0, 0);
        drive(LD, 0, 1, 1, 0); expect_o("dtmo.dec", 1, 6'b000000, 0, 0, 0, 0, 0);
        drive(LD, 0, 1, 1, 0); expect_o("dtmo.exec", 2, 6'b000000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(LD, 0, 1, 0, 0);
            expect_o($sformatf("dtmo.mem%0d", i), 3, 6'b001000, 0, 0, 0, 0, 0);
        end
        drive(LD, 0, 1, 1, 0); expect_o("dtmo.halt", 5, 6'b000000, 0, 0, 1, 1, 0);

        // SW retires, then reset lands mid-MEM of a LW
        do_reset();
        drive(ST, 0, 1, 1, 0); expect_o("rm.sw_fetch", 0, 6'b110000, 0, 0, 0, 0, 0);
        drive(ST, 0, 1, 1, 0); expect_o("rm.sw_dec", 1, 6'b000000, 0, 0, 0, 0, 0);
        drive(ST, 0, 1, 1, 0); expect_o("rm.sw_exec", 2, 6'b000000, 0, 0, 0, 0, 0);
        drive(ST, 0, 1, 1, 0); expect_o("rm.sw_mem", 3, 6'b001101, 0, 0, 0, 0, 0);
        drive(LD, 0, 1, 1, 0); expect_o("rm.lw_fetch", 0, 6'b110000, 0, 0, 0, 0, 1);
        drive(LD, 0, 1, 1, 0); expect_o("rm.lw_dec", 1, 6'b000000, 0, 0, 0, 0, 1);
        drive(LD, 0, 1, 1, 0); expect_o("rm.lw_exec", 2, 6'b000000, 0, 0, 0, 0, 1);
        drive(LD, 0, 1, 0, 0); expect_o("rm.lw_mem", 3, 6'b001000, 0, 0, 0, 0, 1);
        drive(LD, 0, 1, 0, 1); expect_o("rm.rst_hi", 3, 6'b000000, 0, 0, 0, 0, 1);
        drive(LD, 0, 1, 1, 0); expect_o("rm.after", 0, 6'b110000, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
